detect_event_logger: RTL and testbench
======================================

# detect_event_logger

Downstream consumer of the Mealy 1010110 sequence detector. Samples the detector's `detected` strobe every clock and maintains a free-running bit-position counter. Each detection's bit position is pushed into a small FIFO and delivered to a host over a valid/ready handshake. Also keeps a saturating total-detection count and a sticky overflow flag for dropped events.

## Interface

**Parameters**
- `POS_W`, 8, width of bit-position counter and of `ev_pos`.
- `CNT_W`, 8, width of `total_count`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

**Ports**
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low; sampled on rising edge of `clk`.
- `detected`  input  1  detector strobe, one bit sample per clock; combinational from the detector, sampled at the edge.
- `clear`  input  1  synchronous soft clear, active-high.
- `ev_ready`  input  1  host accepts head event.
- `ev_valid`  output  1  FIFO non-empty.
- `ev_pos`  output  POS_W  bit position of head event; valid only while `ev_valid`=1.
- `fifo_level`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `total_count`  output  CNT_W  detections seen since reset/clear, saturating.
- `overflow`  output  1  sticky; a detection was dropped because the FIFO was full.

## Operation

**Reset and clear**
- `reset`=0 at an edge: `pos`, FIFO pointers, `fifo_level`, `total_count` and `overflow` all go to 0. Outputs read `ev_valid`=0, `ev_pos`=0.
- `clear`=1 with `reset`=1 has the same effect. Reset has priority over clear.
- Clear has priority over `detected` and the pop in the same cycle. An event arriving that cycle is discarded and not counted.

**Position counter**
- `pos` increments by 1 every clock, wrapping 2^POS_W−1 → 0.
- The position logged for a detection is the `pos` value in the cycle `detected`=1. That is the index of the bit that completed the pattern, with bit 0 being the first sample after reset/clear.

**Pop**
- `pop` = `ev_valid` & `ev_ready`. It retires the head entry at the edge.
- `ev_ready` while empty has no effect.

**Push**
- `push` = `detected` & (not full | `pop`).
- When full with a simultaneous pop, the push is accepted, the head is retired, and the level stays at DEPTH.

**Drop**
- `detected`=1 while full with no pop: the event is dropped, `overflow` is set, and FIFO contents are unchanged.
- `overflow` clears only on reset or clear.

**Counting and ordering**
- `total_count` increments on every `detected`=1, pushed or dropped, and saturates at 2^CNT_W−1.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `fifo_level` updates by +1 (push only), −1 (pop only), or 0 (both or neither).
- Events leave in strict arrival order.

**Handshake rules**
- `ev_pos` must hold stable while `ev_valid`=1 and `ev_ready`=0.

## Timing

- Detection sampled at edge N; `ev_valid`=1 and `ev_pos` show it after edge N, provided the FIFO was empty. Latency is 1 cycle.
- Pop at edge N: the next entry (or `ev_valid`=0) appears after edge N.
- Back-to-back `detected` pulses every cycle must all be captured until full.
- A full FIFO with `ev_ready` held at 1 sustains one event per cycle with no drops.
- `total_count`, `overflow` and `fifo_level` are registered and reflect edge N immediately after edge N.
- Reset or clear mid-stream: the next sample after the clearing edge is position 0.

## Test plan

1. **Basic capture.** Reset, then drive the input stream 1010110 into the detector; `detected` fires on bit 6 (`pos`=6).
   - `ev_valid`=1 one cycle later with `ev_pos`=6; `total_count`=1.
   - Pulse `ev_ready` → `ev_valid`=0, `fifo_level`=0.
2. **Overflow.** `ev_ready`=0, DEPTH=4, five `detected` pulses at positions 10, 11, 12, 13, 14.
   - `fifo_level`=4, `overflow`=1, `total_count`=5.
   - Draining yields 10, 11, 12, 13 in order.
3. **Full with simultaneous pop.** FIFO full with 20..23; `detected` at `pos`=24 with `ev_ready`=1.
   - Level stays 4, `overflow` stays 0.
   - Drain yields 21, 22, 23, 24.
4. **Wrap and saturate.** POS_W=8: a detection at the 257th sample after reset (index 256) logs `ev_pos`=0. CNT_W=8: 300 detections → `total_count`=255.
5. **Clear and reset priority.** FIFO holding 2 events with `overflow`=1.
   - `clear`=1 with `detected`=1 → next cycle all outputs 0, `total_count`=0; the next sample is `pos` 0.
   - Repeat with `reset`=0 and `clear`=0 → identical result.
6. **Stall stability.** `ev_valid`=1 with `ev_ready`=0 for 10 cycles while new detections are pushed: `ev_pos` constant throughout.

Source files
------------

// File: rtl/detect_event_logger.sv
// Event logger behind the 1010110 sequence detector: tags each detection with its
// bit position, queues it in a small FIFO for a valid/ready host, and keeps a count and a drop flag.
module detect_event_logger #(
    parameter int POS_W = 8,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     detected,
    input  logic                     clear,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [POS_W-1:0]         ev_pos,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         total_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [POS_W-1:0] pos_q, pos_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [POS_W-1:0] mem_q [DEPTH];

    logic full, pop, push;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign ev_valid = (level_q != '0);
    assign pop      = ev_valid & ev_ready;
    // A full FIFO still accepts a detection when the head leaves in the same cycle.
    assign push     = detected & (~full | pop);

    always_comb begin
        pos_d    = pos_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clear) begin
            // Clear outranks both the incoming detection and any pop this cycle.
            pos_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            pos_d = pos_q + POS_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (detected) cnt_d = sat_inc(cnt_q);
            if (detected && !push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !clear && push) mem_q[wr_ptr_q] <= pos_q;
    end

    assign ev_pos      = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level  = level_q;
    assign total_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Scenario bench for detect_event_logger: queue scoreboard for popped positions plus
// per-scenario checks of level, count, overflow and position values.
module tb_detect_event_logger;

    localparam int POS_W = 8;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             detected = 1'b0;
    logic             clear = 1'b0;
    logic             ev_ready = 1'b0;
    logic             ev_valid;
    logic [POS_W-1:0] ev_pos;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] total_count;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [POS_W-1:0] sb_q [$];
    logic [POS_W-1:0] exp_pos = '0;
    int               m_cnt = 0;
    bit               m_ovf = 1'b0;

    detect_event_logger #(.POS_W(POS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .detected(detected), .clear(clear),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_pos(ev_pos),
        .fifo_level(fifo_level), .total_count(total_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; the scoreboard consumes the head when the DUT pops it.
    task automatic tick();
        bit pop_m, full_m;
        logic [POS_W-1:0] head;
        if (!reset || clear) begin
            sb_q.delete();
            m_cnt   = 0;
            m_ovf   = 1'b0;
            exp_pos = '0;
        end else begin
            pop_m  = (sb_q.size() != 0) && ev_ready;
            full_m = (sb_q.size() == DEPTH);
            if (pop_m) begin
                head = sb_q.pop_front();
                n_checks++;
                if (ev_pos !== head) $display("FAIL sb_pop: ev_pos=%0d expected %0d", ev_pos, head);
                else n_pass++;
            end
            if (detected) begin
                if (m_cnt < 255) m_cnt++;
                if (!full_m || pop_m) sb_q.push_back(exp_pos);
                else m_ovf = 1'b1;
            end
            exp_pos = exp_pos + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear = 1'b0; detected = 1'b0; ev_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic advance_to(input logic [POS_W-1:0] p);
        detected = 1'b0;
        for (int i = 0; i < 300 && exp_pos != p; i++) tick();
    endtask

    task automatic drain(input int n);
        detected = 1'b0;
        ev_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL rst_valid: got %0d expected 0", ev_valid); else n_pass++;
        n_checks++; if (ev_pos !== 8'd0) $display("FAIL rst_pos: got %0d expected 0", ev_pos); else n_pass++;
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL rst_level: got %0d expected 0", fifo_level); else n_pass++;
        n_checks++; if (total_count !== 8'd0) $display("FAIL rst_count: got %0d expected 0", total_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0d expected 0", overflow); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            detected = (i == 6);
            tick();
        end
        detected = 1'b0;
        n_checks++; if (ev_valid !== 1'b1) $display("FAIL basic_valid: got %0d expected 1", ev_valid); else n_pass++;
        n_checks++; if (ev_pos !== 8'd6) $display("FAIL basic_pos: got %0d expected 6", ev_pos); else n_pass++;
        n_checks++; if (total_count !== 8'd1) $display("FAIL basic_count: got %0d expected 1", total_count); else n_pass++;
        drain(1);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL basic_empty: got %0d expected 0", ev_valid); else n_pass++;
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL basic_level: got %0d expected 0", fifo_level); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        advance_to(8'd10);
        detected = 1'b1;
        repeat (5) tick();
        detected = 1'b0;
        n_checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0d expected 1", overflow); else n_pass++;
        n_checks++; if (total_count !== 8'd5) $display("FAIL ovf_count: got %0d expected 5", total_count); else n_pass++;
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (ev_pos !== 8'(10 + k)) $display("FAIL ovf_order: got %0d expected %0d", ev_pos, 10 + k); else n_pass++;
            tick();
        end
        ev_ready = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0d expected 1", overflow); else n_pass++;
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL ovf_drained: got %0d expected 0", ev_valid); else n_pass++;
    endtask

    task automatic test_full_pop();
        do_reset();
        advance_to(8'd20);
        detected = 1'b1;
        repeat (4) tick();
        ev_ready = 1'b1;
        tick();
        detected = 1'b0;
        ev_ready = 1'b0;
        n_checks++; if (fifo_level !== 3'd4) $display("FAIL fullpop_level: got %0d expected 4", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %0d expected 0", overflow); else n_pass++;
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (ev_pos !== 8'(21 + k)) $display("FAIL fullpop_order: got %0d expected %0d", ev_pos, 21 + k); else n_pass++;
            tick();
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (256) tick();
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++; if (ev_pos !== 8'd0) $display("FAIL wrap_pos: got %0d expected 0", ev_pos); else n_pass++;
        n_checks++; if (total_count !== 8'd1) $display("FAIL wrap_count: got %0d expected 1", total_count); else n_pass++;
        drain(1);
    endtask

    task automatic test_saturate();
        do_reset();
        detected = 1'b1;
        ev_ready = 1'b1;
        repeat (254) tick();
        n_checks++; if (total_count !== 8'd254) $display("FAIL sat_254: got %0d expected 254", total_count); else n_pass++;
        repeat (46) tick();
        detected = 1'b0;
        n_checks++; if (total_count !== 8'd255) $display("FAIL sat_count: got %0d expected 255", total_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL sat_ovf: got %0d expected 0", overflow); else n_pass++;
        drain(2);
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL sat_level: got %0d expected 0", fifo_level); else n_pass++;
    endtask

    task automatic test_clear(input bit use_reset);
        do_reset();
        detected = 1'b1;
        repeat (5) tick();
        drain(2);
        n_checks++; if (fifo_level !== 3'd2) $display("FAIL clr_pre_level: got %0d expected 2", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL clr_pre_ovf: got %0d expected 1", overflow); else n_pass++;
        if (use_reset) reset = 1'b0; else clear = 1'b1;
        detected = 1'b1;
        ev_ready = 1'b1;
        tick();
        reset = 1'b1; clear = 1'b0; ev_ready = 1'b0;
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL clr_valid (rst=%0d): got %0d expected 0", use_reset, ev_valid); else n_pass++;
        n_checks++; if (ev_pos !== 8'd0) $display("FAIL clr_pos (rst=%0d): got %0d expected 0", use_reset, ev_pos); else n_pass++;
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL clr_level (rst=%0d): got %0d expected 0", use_reset, fifo_level); else n_pass++;
        n_checks++; if (total_count !== 8'd0) $display("FAIL clr_count (rst=%0d): got %0d expected 0", use_reset, total_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf (rst=%0d): got %0d expected 0", use_reset, overflow); else n_pass++;
        tick();
        detected = 1'b0;
        n_checks++; if (ev_pos !== 8'd0) $display("FAIL clr_nextpos (rst=%0d): got %0d expected 0", use_reset, ev_pos); else n_pass++;
        n_checks++; if (total_count !== 8'd1) $display("FAIL clr_nextcnt (rst=%0d): got %0d expected 1", use_reset, total_count); else n_pass++;
        drain(1);
    endtask

    task automatic test_stall();
        do_reset();
        advance_to(8'd3);
        detected = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (ev_pos !== 8'd3) $display("FAIL stall_pos cycle %0d: got %0d expected 3", i, ev_pos); else n_pass++;
            tick();
        end
        detected = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL stall_ovf: got %0d expected 1", overflow); else n_pass++;
        n_checks++; if (total_count !== 8'd11) $display("FAIL stall_count: got %0d expected 11", total_count); else n_pass++;
        drain(4);
        n_checks++; if (ev_valid !== 1'b0) $display("FAIL stall_drained: got %0d expected 0", ev_valid); else n_pass++;
        n_checks++; if (fifo_level !== 3'(sb_q.size())) $display("FAIL stall_sb_level: got %0d expected %0d", fifo_level, sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_saturate();
        test_clear(1'b0);
        test_clear(1'b1);
        test_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
